// File: rtl/util_uart_pkg.sv
// Shared definitions for the UART receiver: the FSM state encoding and the
// parity_type selector values.
package util_uart_pkg;

    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } uart_state_e;

endpackage

// File: rtl/util_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to
// RESET_VAL so an idle-high line looks idle straight out of reset.
module util_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/util_axis_uart_rx.sv
// UART receiver with an AXI-Stream master output and one-cycle error pulses.
// Define UTIL_AXIS_UART_RX_PARITY_EN to receive a parity bit after the data bits.
module util_axis_uart_rx
    import util_uart_pkg::*;
#(
    parameter int baud_clock_speed = 100000000,
    parameter int baud_rate        = 115200,
    parameter int parity_type      = 0,
    parameter int stop_bits        = 1,
    parameter int data_bits        = 8
) (
    input  logic                 aclk,
    input  logic                 arstn,
    input  logic                 rx,
    output logic [data_bits-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int CLKS_PER_BIT = baud_clock_speed / baud_rate;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
    localparam int BIT_W        = 4;

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(data_bits - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(stop_bits - 1);

    generate
        if (data_bits < 5 || data_bits > 8) begin : g_chk_data_bits
            $error("util_axis_uart_rx: data_bits must be 5..8");
        end
        if (stop_bits < 1 || stop_bits > 2) begin : g_chk_stop_bits
            $error("util_axis_uart_rx: stop_bits must be 1 or 2");
        end
        if (parity_type != PARITY_EVEN && parity_type != PARITY_ODD) begin : g_chk_parity
            $error("util_axis_uart_rx: parity_type must be 0 or 1");
        end
        if (CLKS_PER_BIT < 4) begin : g_chk_baud
            $error("util_axis_uart_rx: clock too slow for baud_rate");
        end
    endgenerate

    logic                 rx_s;
    logic                 rx_prev_q;
    uart_state_e          state_q;
    uart_state_e          state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [BIT_W-1:0]     bit_q;
    logic [BIT_W-1:0]     bit_d;
    logic [data_bits-1:0] shift_q;
    logic [data_bits-1:0] shift_d;
    logic [data_bits-1:0] tdata_q;
    logic [data_bits-1:0] tdata_d;
    logic                 tvalid_q;
    logic                 tvalid_d;
    logic                 ferr_q;
    logic                 ferr_d;
    logic                 ovr_q;
    logic                 ovr_d;
    logic                 tick;
    logic                 start_edge;
    logic                 word_done;

`ifdef UTIL_AXIS_UART_RX_PARITY_EN
    localparam logic PAR_ODD = (parity_type == PARITY_ODD);

    logic par_bad_q;
    logic par_bad_d;
    logic perr_q;
    logic perr_d;
`endif

    util_sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .clk  (aclk),
        .rst_n(arstn),
        .d_i  (rx),
        .q_o  (rx_s)
    );

    // The counter holds the cycles left in the current interval, so an
    // interval of N cycles expires on the cycle it reads 1.
    assign tick       = (cnt_q <= CNT_ONE);
    assign start_edge = rx_prev_q & ~rx_s;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick && bit_q == LAST_DATA) begin
`ifdef UTIL_AXIS_UART_RX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef UTIL_AXIS_UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (!rx_s) begin
                        state_d = ST_WAIT_IDLE;
                    end else if (bit_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (tick && rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        word_done = 1'b0;
`ifdef UTIL_AXIS_UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    cnt_d = CNT_HALF;
                    bit_d = '0;
                end
            end
            ST_START: begin
                cnt_d = tick ? CNT_FULL : cnt_q - CNT_ONE;
            end
            ST_DATA: begin
                if (tick) begin
                    cnt_d   = CNT_FULL;
                    shift_d = {rx_s, shift_q[data_bits-1:1]};
                    bit_d   = (bit_q == LAST_DATA) ? '0 : bit_q + BIT_ONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`ifdef UTIL_AXIS_UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    cnt_d     = CNT_FULL;
                    par_bad_d = rx_s ^ (^shift_q) ^ PAR_ODD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    cnt_d = CNT_FULL;
                    if (!rx_s) begin
                        ferr_d = 1'b1;
                        bit_d  = '0;
                    end else if (bit_q == LAST_STOP) begin
                        word_done = 1'b1;
                        bit_d     = '0;
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_WAIT_IDLE: begin
                // Any low sample restarts the full idle bit period.
                if (!rx_s) begin
                    cnt_d = CNT_FULL;
                end else if (!tick) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                cnt_d = '0;
                bit_d = '0;
            end
        endcase

        // A held word accepted on this edge makes room for the new one.
        if (word_done) begin
            if (!tvalid_q || m_axis_tready) begin
                tvalid_d = 1'b1;
                tdata_d  = shift_q;
`ifdef UTIL_AXIS_UART_RX_PARITY_EN
                perr_d   = par_bad_q;
`endif
            end else begin
                ovr_d = 1'b1;
            end
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            rx_prev_q <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_prev_q <= rx_s;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

`ifdef UTIL_AXIS_UART_RX_PARITY_EN
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign frame_err     = ferr_q;
    assign overrun_err   = ovr_q;

endmodule

// File: doc/util_axis_uart_rx.md
UTIL_AXIS_UART_RX -- requirements
Module: util_axis_uart_rx

Interface
REQ-001 SHALL have parameter baud_clock_speed, default 100000000, meaning aclk frequency in Hz.
REQ-002 SHALL have parameter baud_rate, default 115200, meaning serial bit rate.
REQ-003 SHALL have parameter parity_type, default 0, meaning 0 = even, 1 = odd.
REQ-004 SHALL have parameter stop_bits, default 1, meaning stop bits checked (1 or 2).
REQ-005 SHALL have parameter data_bits, default 8, meaning data bits per frame (5..8), LSB first.
REQ-006 SHALL have port aclk, input, 1, the single clock for all logic.
REQ-007 SHALL have port arstn, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port rx, input, 1, asynchronous serial line that idles high.
REQ-009 SHALL have port m_axis_tdata, output, data_bits, received word.
REQ-010 SHALL have port m_axis_tvalid, output, 1, word available.
REQ-011 SHALL have port m_axis_tready, input, 1, downstream accept.
REQ-012 SHALL have ports parity_err, frame_err and overrun_err, output, 1 each, one-cycle error pulses.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer (reset value 1) before any use.
REQ-014 SHALL derive CLKS_PER_BIT = baud_clock_speed/baud_rate with integer truncation; the baud counter SHALL be $clog2(CLKS_PER_BIT)+1 bits wide.
REQ-015 SHALL implement the FSM IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, plus a WAIT_IDLE state.
REQ-016 IDLE: a falling edge on synchronized rx SHALL load CLKS_PER_BIT/2 into the counter and go to START.
REQ-017 START: at count expiry, rx=0 SHALL go to DATA with the counter reloaded to CLKS_PER_BIT; rx=1 is a glitch and SHALL return to IDLE with no output or error.
REQ-018 DATA: SHALL sample once per CLKS_PER_BIT into a shift register LSB first, and exit after data_bits samples.
REQ-019 STOP: SHALL sample each stop bit; any stop sample of 0 SHALL pulse frame_err for 1 cycle, drop the word, and go to WAIT_IDLE.
REQ-020 WAIT_IDLE: SHALL go to IDLE only after rx has been sampled high for one full bit period.
REQ-021 A good frame SHALL assert m_axis_tvalid with tdata on the cycle after the final stop-bit sample (latency 1).
REQ-022 m_axis_tvalid and m_axis_tdata SHALL hold stable until the cycle in which tvalid&&tready is sampled; tvalid SHALL then deassert on the next edge unless a new word loads on the same edge.
REQ-023 If tvalid=1 and tready=0 when a new good word completes, the new word SHALL be dropped, the held word SHALL be kept, and overrun_err SHALL pulse for 1 cycle.
REQ-024 If tready=1 in the completion cycle of a new word, the held word SHALL be accepted and the new word SHALL be loaded with no overrun and no gap in tvalid.
REQ-025 The receiver SHALL never stall on tready; sampling continues regardless.

Reset
REQ-026 arstn=0 SHALL immediately force: FSM to IDLE, counters to 0, synchronizer to 1, m_axis_tdata to 0, m_axis_tvalid to 0, and all error outputs to 0.
REQ-027 Reset asserted mid-frame SHALL discard the partial word; after release, the first falling edge SHALL start a fresh frame.

Configuration
REQ-028 With macro UTIL_AXIS_UART_RX_PARITY_EN defined, the PARITY state SHALL sample one bit after the data bits and compare it with XOR(data) (even) or ~XOR(data) (odd). On mismatch the word SHALL still be output and parity_err SHALL pulse in the same cycle tvalid rises.
REQ-029 Without the macro, the PARITY state and its logic SHALL be absent, DATA SHALL go directly to STOP, and parity_err SHALL be tied 0.

Structure
REQ-030 Shared package util_uart_pkg SHALL hold the FSM state typedef and the parity_type constants (PARITY_EVEN=0, PARITY_ODD=1).
REQ-031 The synchronizer SHALL be the single sub-module util_sync_2ff; all other logic SHALL be flat.

Verification (aclk 50 MHz, baud_rate 5000000, CLKS_PER_BIT = 10)
REQ-032 Reset, then send 8'h41 with 1 stop bit and tready=1 -> one tvalid pulse with tdata=8'h41, no errors, tvalid 1 cycle after the stop mid-sample.
REQ-033 Send 8'hA5 then 8'h5A back-to-back with tready=0 -> tdata holds 8'hA5 and overrun_err pulses once; after tready=1, only 8'hA5 is delivered.
REQ-034 Send a frame with the stop bit forced to 0 -> frame_err pulses, no tvalid; the next good frame 8'h33 after 1 idle bit is received correctly.
REQ-035 Drive a 3-cycle low glitch on rx -> no tvalid and no errors; the FSM returns to IDLE.
REQ-036 With PARITY_EN defined and parity_type=0, send 8'h07 with parity bit 0 -> tdata=8'h07 and parity_err pulses with tvalid; with parity bit 1 -> no parity_err.
REQ-037 Assert arstn=0 during the 4th data bit -> all outputs are 0 immediately; after release, 8'hC3 is received correctly.
